// File: rtl/hilo_div_issuer.sv
// hilo_div_issuer
//   EX-stage requester for a multi-cycle sequential divider, and owner of
//   the architectural HI/LO registers.
//   - DIV/DIVU launch a divide with a one-cycle div_valid pulse. The operands
//     are held in local registers and stay on div_a/div_b/div_sign until the
//     divide finishes. The pipeline is stalled for the whole divide.
//   - MTHI/MTLO write HI/LO directly and never stall.
//   - The divider cannot abort. A flushed divide is therefore drained:
//     its result is discarded, and only then can a new divide be issued.
//   - A watchdog ends any divide that takes too long and raises a sticky
//     timeout_err flag.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   ex_valid, ex_op    EX instruction valid and opcode
//                      (001 DIV, 010 DIVU, 011 MTHI, 100 MTLO)
//   ex_rs, ex_rt       dividend / MTHI-MTLO source, and divisor
//   ex_flush           kills the EX instruction this cycle
//   pipe_stall         holds EX and earlier stages
//   div_valid          start pulse to the divider
//   div_sign           1 selects a signed divide
//   div_a, div_b       operands to the divider
//   div_stall          divider busy flag
//   div_result         {remainder, quotient} from the divider
//   hi, lo             architectural HI (remainder) and LO (quotient)
//   timeout_err        sticky watchdog flag
module hilo_div_issuer #(
  parameter int DATA_W     = 32,
  parameter int MAX_CYCLES = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [2:0]            ex_op,
  input  logic [DATA_W-1:0]     ex_rs,
  input  logic [DATA_W-1:0]     ex_rt,
  input  logic                  ex_flush,
  output logic                  pipe_stall,
  output logic                  div_valid,
  output logic                  div_sign,
  output logic [DATA_W-1:0]     div_a,
  output logic [DATA_W-1:0]     div_b,
  input  logic                  div_stall,
  input  logic [2*DATA_W-1:0]   div_result,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  op_a, op_b;
  logic               op_sign;
  logic [CNT_W-1:0]   cnt;
  logic               seen;        // div_stall has been observed high for the current divide
  logic               op_div, is_div, is_mthi, is_mtlo;
  logic               timeout_hit;
  logic               stall_raw, valid_raw, wr_div, wr_mt;

  assign op_div      = (ex_op == 3'b001) || (ex_op == 3'b010);
  assign is_div      = ex_valid && !ex_flush && op_div;
  assign is_mthi     = ex_valid && !ex_flush && (ex_op == 3'b011);
  assign is_mtlo     = ex_valid && !ex_flush && (ex_op == 3'b100);
  assign timeout_hit = (state != IDLE) && (cnt == CNT_W'(MAX_CYCLES));

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    valid_raw = 1'b0;
    wr_div    = 1'b0;
    wr_mt     = 1'b0;
    case (state)
      IDLE: begin
        valid_raw = is_div;
        stall_raw = is_div;
        wr_mt     = 1'b1;
        if (is_div) state_nxt = ISSUE;
      end
      ISSUE: begin
        stall_raw = 1'b1;
        if (timeout_hit) begin
          stall_raw = 1'b0;
          state_nxt = IDLE;
        end else if (ex_flush) begin
          state_nxt = DRAIN;
        end else if (div_stall) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_raw = div_stall;
        if (timeout_hit) begin
          stall_raw = 1'b0;
          state_nxt = IDLE;
        end else if (ex_flush) begin
          // A flush beats a completion in the same cycle: no HI/LO write.
          state_nxt = DRAIN;
        end else if (!div_stall) begin
          wr_div    = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // A following divide must wait for the divider; MTHI/MTLO may proceed.
        stall_raw = ex_valid && op_div;
        wr_mt     = 1'b1;
        if (timeout_hit) begin
          stall_raw = 1'b0;
          state_nxt = IDLE;
        end else if (seen && !div_stall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_sign     <= 1'b0;
      cnt         <= '0;
      seen        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= timeout_err || timeout_hit;

      if (state == IDLE && is_div) begin
        op_a    <= ex_rs;
        op_b    <= ex_rt;
        op_sign <= (ex_op == 3'b001);
        cnt     <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end

      // If the divide is flushed while still in ISSUE, the divider may not
      // have accepted it yet. DRAIN must then see div_stall rise before it
      // can treat div_stall low as the end of the divide.
      case (state)
        ISSUE:   seen <= div_stall;
        BUSY:    seen <= 1'b1;
        DRAIN:   seen <= seen || div_stall;
        default: seen <= 1'b0;
      endcase

      if (wr_div) begin
        hi <= div_result[2*DATA_W-1:DATA_W];
        lo <= div_result[DATA_W-1:0];
      end else if (wr_mt) begin
        if (is_mthi) hi <= ex_rs;
        if (is_mtlo) lo <= ex_rs;
      end
    end
  end

  // While in reset, all outputs read zero, even when a divide is presented.
  assign pipe_stall = stall_raw && !rst;
  assign div_valid  = valid_raw && !rst;
  assign div_sign   = rst ? 1'b0 : (state == IDLE) ? (ex_op == 3'b001) : op_sign;
  assign div_a      = rst ? '0 : (state == IDLE) ? ex_rs : op_a;
  assign div_b      = rst ? '0 : (state == IDLE) ? ex_rt : op_b;

endmodule

// File: tb/tb_hilo_div_issuer.sv
// Self-checking bench for hilo_div_issuer. It uses a behavioural divider
// with a fixed 4-cycle busy time, and a hang mode that never finishes.
module tb_hilo_div_issuer;

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam int         LAT     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op = 3'b000;
  logic [31:0] ex_rs = '0;
  logic [31:0] ex_rt = '0;
  logic        ex_flush = 1'b0;
  logic        pipe_stall, div_valid, div_sign;
  logic [31:0] div_a, div_b, hi, lo;
  logic        div_stall;
  logic [63:0] div_result;
  logic        timeout_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  hilo_div_issuer #(.DATA_W(32), .MAX_CYCLES(127)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_flush(ex_flush), .pipe_stall(pipe_stall),
    .div_valid(div_valid), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
    .div_stall(div_stall), .div_result(div_result), .hi(hi), .lo(lo),
    .timeout_err(timeout_err)
  );

  // Behavioural divider: busy for LAT cycles after accepting div_valid.
  // Its result is computed from the live operand inputs.
  logic hang = 1'b0;
  int   busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_stall <= 1'b0;
      busy_cnt  <= 0;
    end else if (div_valid && !div_stall) begin
      div_stall <= 1'b1;
      busy_cnt  <= LAT;
    end else if (div_stall && !hang) begin
      if (busy_cnt == 1) div_stall <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  logic signed [31:0] sa, sb, sq, sr;
  always_comb begin
    sa = div_a;
    sb = div_b;
    sq = '0;
    sr = '0;
    div_result = '0;
    if (div_b != 0) begin
      if (div_sign) begin
        sq = sa / sb;
        sr = sa % sb;
        div_result = {sr, sq};
      end else begin
        div_result = {div_a % div_b, div_a / div_b};
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a divide in EX and holds it until the pipeline stops stalling.
  task automatic run_div(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input bit scramble, input int limit,
                         output int stalls, output int pulses, output logic sign0,
                         output logic [31:0] hi_iss, output bit a_bad, output bit done);
    logic st;
    ex_valid = 1'b1; ex_op = op; ex_rs = rs; ex_rt = rt;
    stalls = 0; pulses = 0; sign0 = 1'b0; hi_iss = '0; a_bad = 1'b0; done = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (div_valid) begin
        pulses++;
        if (pulses == 1) begin
          sign0  = div_sign;
          hi_iss = hi;
        end
      end
      if (div_a !== rs || div_b !== rt) a_bad = 1'b1;
      st = pipe_stall;
      if (st) stalls++;
      @(posedge clk); #1;
      if (scramble) begin
        ex_rs = $urandom;
        ex_rt = $urandom;
      end
      if (!st) begin
        done = 1'b1;
        break;
      end
    end
    ex_valid = 1'b0; ex_op = 3'b000;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] val);
    ex_valid = 1'b1; ex_op = op; ex_rs = val;
    @(negedge clk);
    chk("mt_no_stall", {63'd0, pipe_stall}, 64'd0);
    chk("mt_no_valid", {63'd0, div_valid}, 64'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = 3'b000;
  endtask

  int          stalls, pulses;
  logic        sign0;
  logic [31:0] hi_iss;
  bit          a_bad, done;

  initial begin
    // Reset state
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_stall", {63'd0, pipe_stall}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // DIV -7 / 2
    run_div(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 50, stalls, pulses, sign0, hi_iss, a_bad, done);
    chk("div1_done", {63'd0, done}, 64'd1);
    chk("div1_pulses", 64'(pulses), 64'd1);
    chk("div1_sign", {63'd0, sign0}, 64'd1);
    chk("div1_stalls", 64'(stalls), 64'd5);
    chk("div1_lo", {32'd0, lo}, 64'hFFFFFFFD);
    chk("div1_hi", {32'd0, hi}, 64'hFFFFFFFF);

    // DIVU 0xFFFFFFFF / 1, with EX operands scrambled after issue
    run_div(OP_DIVU, 32'hFFFFFFFF, 32'd1, 1'b1, 50, stalls, pulses, sign0, hi_iss, a_bad, done);
    chk("divu_done", {63'd0, done}, 64'd1);
    chk("divu_ops_held", {63'd0, a_bad}, 64'd0);
    chk("divu_sign", {63'd0, sign0}, 64'd0);
    chk("divu_pulses", 64'(pulses), 64'd1);
    chk("divu_lo", {32'd0, lo}, 64'hFFFFFFFF);
    chk("divu_hi", {32'd0, hi}, 64'd0);

    // MTHI then MTLO
    do_mt(OP_MTHI, 32'h12345678);
    chk("mthi_hi", {32'd0, hi}, 64'h12345678);
    do_mt(OP_MTLO, 32'h9ABCDEF0);
    chk("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
    chk("mtlo_hi_kept", {32'd0, hi}, 64'h12345678);

    // Flush mid-BUSY, then a new divide waits for the drain
    do_mt(OP_MTHI, 32'hAAAAAAAA);
    do_mt(OP_MTLO, 32'hAAAAAAAA);
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs = 32'd100; ex_rt = 32'd3;
    @(negedge clk);
    chk("fl_issue_pulse", {63'd0, div_valid}, 64'd1);
    @(posedge clk); #1;                // ISSUE
    @(posedge clk); #1;                // BUSY
    ex_flush = 1'b1;
    @(posedge clk); #1;                // DRAIN
    ex_flush = 1'b0;
    run_div(OP_DIVU, 32'd9, 32'd2, 1'b0, 50, stalls, pulses, sign0, hi_iss, a_bad, done);
    chk("fl_done", {63'd0, done}, 64'd1);
    chk("fl_hi_at_issue", {32'd0, hi_iss}, 64'hAAAAAAAA);
    chk("fl_pulses", 64'(pulses), 64'd1);
    chk("fl_stalls", 64'(stalls), 64'd8);
    chk("fl_lo", {32'd0, lo}, 64'd4);
    chk("fl_hi", {32'd0, hi}, 64'd1);

    // Asynchronous reset mid-BUSY
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs = 32'd50; ex_rt = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    chk("arst_stall", {63'd0, pipe_stall}, 64'd0);
    chk("arst_valid", {63'd0, div_valid}, 64'd0);
    ex_valid = 1'b0; ex_op = 3'b000;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_div(OP_DIV, 32'd20, 32'hFFFFFFFD, 1'b0, 50, stalls, pulses, sign0, hi_iss, a_bad, done);
    chk("post_rst_done", {63'd0, done}, 64'd1);
    chk("post_rst_lo", {32'd0, lo}, 64'hFFFFFFFA);
    chk("post_rst_hi", {32'd0, hi}, 64'd2);
    chk("pre_wd_timeout", {63'd0, timeout_err}, 64'd0);

    // Hung divider triggers the watchdog
    hang = 1'b1;
    run_div(OP_DIV, 32'd8, 32'd2, 1'b0, 400, stalls, pulses, sign0, hi_iss, a_bad, done);
    chk("wd_released", {63'd0, done}, 64'd1);
    chk("wd_timeout", {63'd0, timeout_err}, 64'd1);
    chk("wd_lo_kept", {32'd0, lo}, 64'hFFFFFFFA);
    chk("wd_hi_kept", {32'd0, hi}, 64'd2);
    @(negedge clk);
    chk("wd_stall_low", {63'd0, pipe_stall}, 64'd0);
    @(posedge clk); #1;
    do_mt(OP_MTHI, 32'h00000055);
    chk("wd_idle_mthi", {32'd0, hi}, 64'h55);
    chk("wd_sticky", {63'd0, timeout_err}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hilo_div_issuer.md
Name: hilo_div_issuer

Overview:
- Requester side of the sequential divider handshake, in the EX stage.
- Decodes DIV/DIVU/MTHI/MTLO from EX and launches a divide with a one-cycle valid pulse.
- Holds operands stable and stalls the pipeline while the divider runs, then writes the result into architectural HI/LO.
- Drains the divider on pipeline flush, since the divider cannot abort, and owns the HI/LO registers.

Parameters:
- DATA_W, 32, operand/HI/LO width (only 32 supported).
- MAX_CYCLES, 127, watchdog limit on cycles spent in ISSUE/BUSY/DRAIN before timeout_err.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX-stage instruction valid.
- ex_op  in  3  000 none, 001 DIV (signed), 010 DIVU, 011 MTHI, 100 MTLO, others treated as none.
- ex_rs  in  32  dividend / MTHI/MTLO source.
- ex_rt  in  32  divisor.
- ex_flush  in  1  kills the EX instruction this cycle; has priority over every write/issue.
- pipe_stall  out  1  hold EX and earlier stages.
- div_valid  out  1  start pulse to divider.
- div_sign  out  1  1 = signed divide.
- div_a  out  32  dividend to divider.
- div_b  out  32  divisor to divider.
- div_stall  in  1  divider busy; rises the cycle after an accepted div_valid.
- div_result  in  64  {remainder, quotient}; valid only while div_stall=0 and only relative to current div_a/div_b/div_sign.
- hi  out  32  architectural HI (remainder).
- lo  out  32  architectural LO (quotient).
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset: state IDLE, hi=lo=0, operand regs=0, counter=0, timeout_err=0. All outputs go to 0 immediately on async rst, including mid-operation; the divider shares rst.
- is_div = ex_valid & !ex_flush & (ex_op==001 | ex_op==010).
- IDLE:
  - div_a/div_b/div_sign are driven combinationally from ex_rs/ex_rt/(ex_op==001).
  - div_valid = is_div; pipe_stall = is_div.
  - On is_div: latch operands and sign into op regs; go to ISSUE.
  - On MTHI/MTLO with ex_valid & !ex_flush: write hi or lo at the edge; no stall.
- ISSUE, BUSY and DRAIN: div_a/div_b/div_sign come from the op regs. They must stay constant until completion, because the divider sign-corrects its result from these live inputs.
- ISSUE (waiting for the divider to accept): pipe_stall=1, div_valid=0. When div_stall=1, go to BUSY. Completion is never accepted before div_stall has been seen high.
- BUSY:
  - pipe_stall=1 while div_stall=1.
  - When div_stall=0: hi<=div_result[63:32], lo<=div_result[31:0] at this edge; pipe_stall=0 this cycle so the divide retires; go to IDLE. No extra bubble.
- Flush in ISSUE or BUSY: go to DRAIN. No HI/LO write at that edge, even if div_stall=0 in the same cycle (flush wins).
- DRAIN:
  - pipe_stall = ex_valid & (ex_op==001|010): a new divide waits.
  - MTHI/MTLO are accepted and written.
  - In ISSUE-origin drain, wait for div_stall to be seen high, then low.
  - When div_stall=0 after being seen high: discard div_result and go to IDLE. A waiting divide is issued from IDLE on the next cycle.
- Watchdog: counter clears on entry to ISSUE and increments each cycle in ISSUE/BUSY/DRAIN. When it reaches MAX_CYCLES: set timeout_err (sticky until rst), drop pipe_stall, go to IDLE, leave HI/LO unchanged.
- Divide by zero: result is architecturally unpredictable; whatever the divider returns is written, with no special handling.
- div_valid is never asserted outside IDLE. Exactly one pulse per divide.

Test Plan:
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> one-cycle div_valid, div_sign=1, pipe_stall high from issue cycle through the cycle before completion, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0xFFFFFFFF, rt=1 with ex_rs/ex_rt randomised after issue -> div_a/div_b stay 0xFFFFFFFF/1 throughout; lo=0xFFFFFFFF, hi=0.
- IDLE MTHI rs=0x12345678, next cycle MTLO rs=0x9ABCDEF0 -> hi/lo updated at each edge; pipe_stall=0 and div_valid=0 throughout.
- HI/LO preloaded 0xAAAAAAAA; DIV 100/3 flushed mid-BUSY, new DIVU 9/2 presented -> HI/LO untouched by the first divide; second divide issues only after drain; final lo=4, hi=1.
- rst asserted mid-BUSY -> same cycle hi=lo=0, pipe_stall=0, div_valid=0; a DIV issued after release completes normally.
- Divider model holds div_stall=1 forever -> timeout_err=1 after MAX_CYCLES, pipe_stall=0, state IDLE, HI/LO unchanged.
